// File: rtl/mac_tx_fcs.sv
// rtl/mac_tx_fcs.sv - byte-wide TX framing: forward frame, zero-pad to minimum, append CRC-32 FCS
module mac_tx_fcs #(
  parameter int          MIN_FRAME_BYTES = 60,
  parameter bit          PAD_ENABLE      = 1'b1,
  parameter logic [31:0] INITIAL_CRC     = 32'hFFFFFFFF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  input  logic       m_tready,
  output logic       o_busy
);

  typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FCS} state_t;

  localparam logic [16:0] MIN_P1_CMP = 17'(MIN_FRAME_BYTES);
  localparam logic [15:0] MIN_CNT    = 16'(MIN_FRAME_BYTES);

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  tdata_d;
  logic        tvalid_d, tlast_d;
  logic        adv;
  logic [15:0] count_inc;
  logic [16:0] count_p1;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign adv       = !m_tvalid || m_tready;
  assign count_p1  = {1'b0, count_q} + 17'd1;
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_p1[15:0];
  assign fcs       = ~crc_q;
  assign o_busy    = (state_q != ST_DATA) || (count_q != 16'd0);

  always_comb begin
    case (idx_q)
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    count_d  = count_q;
    idx_d    = idx_q;
    tdata_d  = m_tdata;
    tvalid_d = m_tvalid;
    tlast_d  = m_tlast;
    s_tready = 1'b0;
    case (state_q)
      ST_DATA: begin
        s_tready = adv;
        if (s_tvalid && adv) begin
          tdata_d  = s_tdata;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          crc_d    = crc_byte(crc_q, s_tdata);
          count_d  = count_inc;
          if (s_tlast) begin
            idx_d = 2'd0;
            if (PAD_ENABLE && (count_p1 < MIN_P1_CMP)) state_d = ST_PAD;
            else                                       state_d = ST_FCS;
          end
        end else if (adv) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      ST_PAD: begin
        if (adv) begin
          tdata_d  = 8'h00;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          crc_d    = crc_byte(crc_q, 8'h00);
          count_d  = count_inc;
          if (count_inc == MIN_CNT) begin
            idx_d   = 2'd0;
            state_d = ST_FCS;
          end
        end
      end
      default: begin
        if (adv) begin
          tdata_d  = fcs_byte;
          tvalid_d = 1'b1;
          tlast_d  = (idx_q == 2'd3);
          idx_d    = idx_q + 2'd1;
          // Last FCS byte re-arms the CRC so the next frame can start without a bubble.
          if (idx_q == 2'd3) begin
            crc_d   = INITIAL_CRC;
            count_d = 16'd0;
            idx_d   = 2'd0;
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_DATA;
      crc_q    <= INITIAL_CRC;
      count_q  <= 16'd0;
      idx_q    <= 2'd0;
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      m_tdata  <= tdata_d;
      m_tvalid <= tvalid_d;
      m_tlast  <= tlast_d;
    end
  end

endmodule

// File: doc/mac_tx_fcs.md
# mac_tx_fcs

Byte-wide transmit framing stage of the 10G MAC. It accepts an outgoing frame (destination MAC through end of payload) as a byte stream and forwards it unchanged. Frames shorter than the Ethernet minimum are zero-padded, and the 4-byte IEEE 802.3 FCS is appended. It sits between the TX frame source and the byte-to-word gearbox that feeds the PCS.

## Interface
Parameters:
- `MIN_FRAME_BYTES`, default 60: minimum byte count before FCS; shorter frames are padded up to this length.
- `PAD_ENABLE`, default 1: 1 = pad short frames; 0 = never pad.
- `INITIAL_CRC`, default 32'hFFFFFFFF: CRC register value at the start of each frame.

Ports:
- `i_clk`, in, 1: single clock for all logic.
- `i_reset`, in, 1: reset is synchronous and active-high.
- `s_tdata`, in, 8: input frame byte.
- `s_tvalid`, in, 1: input byte valid.
- `s_tlast`, in, 1: marks the last input byte of the frame.
- `s_tready`, out, 1: block accepts the input byte this cycle.
- `m_tdata`, out, 8: output byte (data, pad or FCS).
- `m_tvalid`, out, 1: output byte valid.
- `m_tlast`, out, 1: marks the last FCS byte.
- `m_tready`, in, 1: downstream accepts the output byte.
- `o_busy`, out, 1: high while a frame is in progress (DATA with count > 0, PAD or FCS).

## Operation
- Output is a registered stage: `m_tdata`, `m_tvalid` and `m_tlast` are flops.
- adv = !m_tvalid || m_tready. When adv is high, the output register may load a new byte.
- CRC function:
  - Reflected CRC-32, polynomial 0xEDB88320, processed LSB-first, one byte per update.
  - Update rule: crc ← (crc >> 8) ^ T[crc[7:0] ^ byte].
  - FCS = ~crc, transmitted as bytes [7:0], [15:8], [23:16], [31:24] in that order.
- Byte counter: 16 bits, saturating at 16'hFFFF. It counts data and pad bytes loaded into the output register.
- State machine:
  - **DATA** (reset state):
    - `s_tready` = adv.
    - When `s_tvalid && s_tready`: load `s_tdata` with `m_tvalid` = 1 and `m_tlast` = 0, update the CRC, and increment count.
    - If adv is high and no byte is accepted: `m_tvalid` ← 0.
    - On an accepted byte with `s_tlast`: if PAD_ENABLE and count+1 < MIN_FRAME_BYTES, go to PAD; otherwise go to FCS with idx = 0.
  - **PAD**:
    - `s_tready` = 0.
    - On adv: load 0x00, update the CRC, increment count.
    - When the new count equals MIN_FRAME_BYTES, go to FCS with idx = 0.
  - **FCS**:
    - `s_tready` = 0. The CRC is frozen.
    - On adv: load FCS byte idx and increment idx.
    - For idx = 3: set `m_tlast` = 1, reset the CRC to INITIAL_CRC and count to 0, and return to DATA.
- `m_tlast` clears when the next byte is loaded, or when `m_tvalid` drops.
- A 1-byte frame with PAD_ENABLE=1 produces 60 bytes (1 data + 59 pad) followed by 4 FCS bytes.
- Frames of MIN_FRAME_BYTES or more are never padded.
- The count saturates at 16'hFFFF on jumbo frames; framing is unaffected.

## Timing
- Reset values:
  - State = DATA, CRC = INITIAL_CRC, count = 0, idx = 0.
  - `m_tdata` = 0, `m_tvalid` = 0, `m_tlast` = 0, `o_busy` = 0.
  - `s_tready` = 1 in the first cycle after reset.
- Latency: an input byte accepted at cycle N appears on `m_tdata` at cycle N+1.
- Throughput: 1 byte per cycle with `m_tready` held high. There are no bubbles between the last data byte and pad/FCS, or between the FCS and the next frame's first byte.
- Backpressure: while `m_tvalid && !m_tready`, `m_tdata`, `m_tlast` and the CRC hold, and `s_tready` = 0.
- `s_tready` is combinational from `m_tready`, `m_tvalid` and state. No combinational path exists from `s_tvalid` to `m_*`.
- Reset mid-frame: the partial frame is discarded. Any held output byte is dropped (`m_tvalid` = 0 on the next cycle). The next accepted byte starts a fresh CRC.
- Simultaneous `i_reset` with any handshake: reset wins and no byte is transferred.

## Test plan
- PAD_ENABLE=0, send ASCII "123456789" (0x31..0x39) with `m_tready`=1: output is the 9 bytes, then 0x26 0x39 0xF4 0xCB with `m_tlast` on 0xCB. There are 13 consecutive valid cycles, and the first output byte appears 1 cycle after the first accept.
- PAD_ENABLE=1, send a 1-byte frame 0x00: output is exactly 64 bytes, the first 60 are 0x00, and the last 4 match the reference-model CRC of 60 zero bytes. `s_tready` = 0 during the 59 pad and 4 FCS cycles.
- 60-byte and 61-byte frames: no pad. Output is 64 and 65 bytes respectively, with correct FCS.
- Random `m_tready` and `s_tvalid` toggling over 200 random frames (1–1518 bytes): every output frame matches the model (pad + FCS) and no byte is lost or duplicated. `m_tdata` is stable while `m_tvalid && !m_tready`.
- Back-to-back frames: 64-byte frame A followed immediately by frame B. B's first byte is accepted in the cycle after A's last FCS byte loads, and B's FCS is computed from INITIAL_CRC.
- Assert `i_reset` for 1 cycle after 20 bytes of a frame: `m_tvalid` = 0 and `o_busy` = 0 the next cycle. A following "123456789" frame (PAD_ENABLE=0) still ends in 0x26 0x39 0xF4 0xCB.
